// File: rtl/rx_assembler_pkg.sv
// Shared types and helpers for the receive operand assembler.
package rx_assembler_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    CHECK  = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] CHK_INIT = 8'h00;

  function automatic int bytes_per_frame(input int w, input int n);
    return (n * w) / 8;
  endfunction

endpackage

// File: rtl/rx_operand_assembler_if.sv
// Byte-stream input and operand-frame output bundle of the assembler.
interface rx_operand_assembler_if #(
  parameter int OPERAND_W    = 256,
  parameter int NUM_OPERANDS = 2
);
  import rx_assembler_pkg::*;

  localparam int FRAME_BYTES = bytes_per_frame(OPERAND_W, NUM_OPERANDS);
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);

  logic                              en_rx;
  logic [7:0]                        i_data_byte;
  logic                              i_data_avail;
  logic [NUM_OPERANDS*OPERAND_W-1:0] o_operands;
  logic                              o_valid;
  logic                              i_ready;
  logic [CNT_W-1:0]                  o_byte_count;
  logic                              o_err_timeout;
  logic                              o_overrun;
  logic                              o_err_chk;

  modport master (
    output en_rx, i_data_byte, i_data_avail, i_ready,
    input  o_operands, o_valid, o_byte_count, o_err_timeout, o_overrun, o_err_chk
  );

  modport slave (
    input  en_rx, i_data_byte, i_data_avail, i_ready,
    output o_operands, o_valid, o_byte_count, o_err_timeout, o_overrun, o_err_chk
  );

endinterface

// File: rtl/rx_operand_assembler_gap_timer.sv
// rx_gap_timer: inter-byte gap down-counter; load restarts the gap, expire
// strobes on the last counted cycle. TIMEOUT_CYCLES=0 removes the timer.
module rx_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_timer;
      assign unused_timer = ^{clock, reset, load, clear, en};
      assign expire       = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] rem;

      always_ff @(posedge clock or posedge reset) begin
        if (reset)                     rem <= '0;
        else if (load)                 rem <= TW'(TIMEOUT_CYCLES);
        else if (clear)                rem <= '0;
        else if (en && rem != '0)      rem <= rem - 1'b1;
      end

      assign expire = en && (rem == TW'(1));
    end
  endgenerate

endmodule

// File: rtl/rx_operand_assembler.sv
// Assembles a little-endian byte stream into NUM_OPERANDS x OPERAND_W operands
// with valid/ready hand-off and inter-byte timeout. Optional: RX_CHECKSUM_EN.
module rx_operand_assembler
  import rx_assembler_pkg::*;
#(
  parameter int OPERAND_W      = 256,
  parameter int NUM_OPERANDS   = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                   clock,
  input logic                   reset,
  rx_operand_assembler_if.slave bus
);

  localparam int FRAME_BYTES = bytes_per_frame(OPERAND_W, NUM_OPERANDS);
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int BI_W        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

  state_t                            state, state_n;
  logic [CNT_W-1:0]                  count, count_n;
  logic [NUM_OPERANDS*OPERAND_W-1:0] operands;
  logic                              wr_en;
  logic                              tmo, tmo_n, ovr, ovr_n, err, err_n;
  logic                              tmr_load, tmr_clear, tmr_en, tmr_expire;
  logic                              byte_in;

  assign byte_in = bus.en_rx & bus.i_data_avail;

`ifdef RX_CHECKSUM_EN
  logic [7:0] chk, chk_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chk <= CHK_INIT;
    else       chk <= chk_n;
  end
`endif

  rx_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (tmr_load),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_n   = state;
    count_n   = count;
    wr_en     = 1'b0;
    tmo_n     = 1'b0;
    ovr_n     = 1'b0;
    err_n     = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
`ifdef RX_CHECKSUM_EN
    chk_n     = chk;
`endif
    // Only a partially received frame ages; an arriving byte always beats expiry.
    tmr_en    = bus.en_rx && (state != HOLD) && (count != '0) && !byte_in;
    unique case (state)
      ACCEPT: begin
        if (byte_in) begin
          wr_en    = 1'b1;
          count_n  = count + 1'b1;
          tmr_load = 1'b1;
`ifdef RX_CHECKSUM_EN
          chk_n    = ((count == '0) ? CHK_INIT : chk) ^ bus.i_data_byte;
          if (count == LAST) state_n = CHECK;
`else
          if (count == LAST) state_n = HOLD;
`endif
        end else if (tmr_expire) begin
          tmo_n     = 1'b1;
          count_n   = '0;
          tmr_clear = 1'b1;
        end
      end
`ifdef RX_CHECKSUM_EN
      CHECK: begin
        if (byte_in) begin
          tmr_clear = 1'b1;
          if (bus.i_data_byte == chk) begin
            state_n = HOLD;
          end else begin
            err_n   = 1'b1;
            count_n = '0;
            state_n = ACCEPT;
          end
        end else if (tmr_expire) begin
          tmo_n     = 1'b1;
          count_n   = '0;
          tmr_clear = 1'b1;
          state_n   = ACCEPT;
        end
      end
`endif
      HOLD: begin
        ovr_n = byte_in;
        if (bus.i_ready) begin
          state_n = ACCEPT;
          count_n = '0;
        end
      end
      default: state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ACCEPT;
      count    <= '0;
      operands <= '0;
      tmo      <= 1'b0;
      ovr      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      tmo   <= tmo_n;
      ovr   <= ovr_n;
      err   <= err_n;
      // Byte lane = count*8; older bytes stay until overwritten.
      if (wr_en) operands[{count[BI_W-1:0], 3'b000} +: 8] <= bus.i_data_byte;
    end
  end

  assign bus.o_operands    = operands;
  assign bus.o_valid       = (state == HOLD);
  assign bus.o_byte_count  = count;
  assign bus.o_err_timeout = tmo;
  assign bus.o_overrun     = ovr;
`ifdef RX_CHECKSUM_EN
  assign bus.o_err_chk     = err;
`else
  assign bus.o_err_chk     = 1'b0;
  logic unused_err;
  assign unused_err = err;
`endif

endmodule

// File: tb/tb_rx_operand_assembler.sv
// Directed bench for rx_operand_assembler (16-bit x 2 operands, timeout 20).
module tb_rx_operand_assembler;

  localparam int OW = 16;
  localparam int NO = 2;
  localparam int TO = 20;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic seen;

  rx_operand_assembler_if #(.OPERAND_W(OW), .NUM_OPERANDS(NO)) bus ();

  rx_operand_assembler #(
    .OPERAND_W(OW), .NUM_OPERANDS(NO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_data_byte  = b;
    bus.i_data_avail = 1'b1;
    tick();
    bus.i_data_avail = 1'b0;
  endtask

  // Trailing checksum byte, only when the frame carries one.
  task automatic send_chk(input logic [7:0] x);
`ifdef RX_CHECKSUM_EN
    send(x);
`else
    if (x == 8'hxx) tick();
`endif
  endtask

  task automatic handshake();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.en_rx        = 1'b1;
    bus.i_data_byte  = 8'h00;
    bus.i_data_avail = 1'b0;
    bus.i_ready      = 1'b0;
    reset = 1'b1;
    #12 reset = 1'b0;
    tick();

    check("rst_valid",  64'(bus.o_valid), 64'h0);
    check("rst_ops",    64'(bus.o_operands), 64'h0);
    check("rst_count",  64'(bus.o_byte_count), 64'h0);
    check("rst_pulses", 64'({bus.o_err_timeout, bus.o_overrun, bus.o_err_chk}), 64'h0);

    // 1: first frame, consumer not ready
    send(8'h11); send(8'h22); send(8'h33);
    check("t1_valid_early", 64'(bus.o_valid), 64'h0);
    check("t1_count3",      64'(bus.o_byte_count), 64'h3);
    send(8'h44);
    send_chk(8'h44);
    check("t1_valid",  64'(bus.o_valid), 64'h1);
    check("t1_ops",    64'(bus.o_operands), 64'h4433_2211);
    check("t1_count",  64'(bus.o_byte_count), 64'h4);
    tick(); tick(); tick();
    check("t1_hold",   64'(bus.o_valid), 64'h1);

    // 2: hand-off, then second frame overwrites byte by byte
    handshake();
    check("t2_valid_drop", 64'(bus.o_valid), 64'h0);
    check("t2_count0",     64'(bus.o_byte_count), 64'h0);
    send(8'h55);
    check("t2_partial", 64'(bus.o_operands), 64'h4433_2255);
    send(8'h66); send(8'h77); send(8'h88);
    send_chk(8'hCC);
    check("t2_valid", 64'(bus.o_valid), 64'h1);
    check("t2_ops",   64'(bus.o_operands), 64'h8877_6655);
    handshake();

    // 3: stalled frame times out after TO idle cycles
    send(8'h11); send(8'h22);
    seen = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      seen = seen | bus.o_err_timeout;
    end
    check("t3_no_early_tmo", 64'(seen), 64'h0);
    check("t3_count_kept",   64'(bus.o_byte_count), 64'h2);
    tick();
    check("t3_tmo_pulse", 64'(bus.o_err_timeout), 64'h1);
    check("t3_count0",    64'(bus.o_byte_count), 64'h0);
    tick();
    check("t3_tmo_once",  64'(bus.o_err_timeout), 64'h0);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    send_chk(8'h04);
    check("t3_valid", 64'(bus.o_valid), 64'h1);
    check("t3_ops",   64'(bus.o_operands), 64'hA4A3_A2A1);

    // 4: byte while holding is dropped
    send(8'h5A);
    check("t4_overrun", 64'(bus.o_overrun), 64'h1);
    check("t4_ops",     64'(bus.o_operands), 64'hA4A3_A2A1);
    check("t4_valid",   64'(bus.o_valid), 64'h1);
    tick();
    check("t4_ovr_once", 64'(bus.o_overrun), 64'h0);
    handshake();

    // 5: receiver disabled mid-frame freezes everything
    send(8'hC1); send(8'hC2);
    bus.en_rx = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen = seen | bus.o_err_timeout;
    end
    send(8'hFF);
    check("t5_no_tmo",   64'(seen), 64'h0);
    check("t5_count",    64'(bus.o_byte_count), 64'h2);
    bus.en_rx = 1'b1;
    send(8'hC3); send(8'hC4);
    send_chk(8'h04);
    check("t5_valid", 64'(bus.o_valid), 64'h1);
    check("t5_ops",   64'(bus.o_operands), 64'hC4C3_C2C1);
    handshake();

`ifdef RX_CHECKSUM_EN
    // 6: checksum good, then bad
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0F);
    check("t6_good_valid", 64'(bus.o_valid), 64'h1);
    check("t6_good_ops",   64'(bus.o_operands), 64'h0804_0201);
    handshake();
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0E);
    check("t6_bad_err",   64'(bus.o_err_chk), 64'h1);
    check("t6_bad_valid", 64'(bus.o_valid), 64'h0);
    check("t6_bad_count", 64'(bus.o_byte_count), 64'h0);
`else
    check("t6_chk_tied0", 64'(bus.o_err_chk), 64'h0);
`endif

    // 7: asynchronous reset while holding a frame
    send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
    send_chk(8'h04);
    check("t7_pre_valid", 64'(bus.o_valid), 64'h1);
    #3 reset = 1'b1;
    #1;
    check("t7_async_valid", 64'(bus.o_valid), 64'h0);
    check("t7_async_ops",   64'(bus.o_operands), 64'h0);
    check("t7_async_count", 64'(bus.o_byte_count), 64'h0);
    #2 reset = 1'b0;
    tick();
    check("t7_post_valid", 64'(bus.o_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
